reg_bus: RTL and testbench
==========================

REG_BUS -- requirements
Module: reg_bus

Interface
REQ-001 SHALL have ports: clk  input  1  system clock, rising-edge active.
REQ-002 SHALL have ports: rst  input  1  asynchronous active-high reset.
REQ-003 SHALL have ports: read_en  input  4  bus source select from control.
REQ-004 SHALL have ports: write_en, inc_en, clr_en  input  16 each  per-register strobes from control.
REQ-005 SHALL have ports: alu_result  input  16  ALU output, the AC load source for write_en[12].
REQ-006 SHALL have ports: im_rdata, dm_rdata  input  16 each  instruction/data memory read data.
REQ-007 SHALL have ports: bus  output  16  shared data bus (combinational).
REQ-008 SHALL have ports: im_addr (=PC), dm_addr (=AR), dm_wdata (=bus)  output  16 each.
REQ-009 SHALL have ports: dm_we  output  1  equals write_en[11].
REQ-010 SHALL have ports: alu_a (=AC), alu_b (=R)  output  16 each.
REQ-011 SHALL have ports: instruction  output  5  IR[4:0]; z  output  16  z[0] zero flag, z[15:1] constant 0.

Function
REQ-012 SHALL hold 16-bit registers PC, AR, IR, AC, R, R1, R2, R3, R4.
REQ-013 SHALL map strobe bits: 1 PC, 2 AR, 3 IR, 4 AC, 5 R, 7 R4, 8 R3, 9 R2, 10 R1; write_en[12] loads AC from alu_result; bits 0, 6, 13-15 reserved and ignored.
REQ-014 SHALL drive bus from read_en: 0 zero, 1 PC, 2 AR, 3 zero, 4 IR, 5 AC, 6 R, 7 R1, 8 R2, 9 R3, 10 R4, 11 zero, 12 dm_rdata, 13 im_rdata, 14 AC, 15 zero.
REQ-015 SHALL update every register on the rising clk edge where its strobe is high; no internal latency beyond one edge.
REQ-016 SHALL apply per-register priority clr > bus write > ALU write (AC only) > increment; lower-priority strobes in the same cycle are dropped.
REQ-017 SHALL increment modulo 2^16 (FFFF -> 0000, no carry out).
REQ-018 SHALL let several registers load the same bus value in one cycle when multiple write bits are set.
REQ-019 SHALL register z[0] on every edge as (next AC value == 0), so z[0] always equals (AC == 0) after the edge.
REQ-020 SHALL leave registers with no active strobe unchanged.
REQ-021 SHALL drive dm_we combinationally, even when read_en selects zero.

Reset
REQ-022 SHALL on rst high clear all registers to 0000 and set z[0]=1 immediately, without waiting for clk.
REQ-023 SHALL ignore all strobes while rst is high; the first update occurs on the first rising edge after rst deasserts.
REQ-024 SHALL, if rst asserts mid-instruction, discard any pending load; the preceding register contents are lost.

Configuration
REQ-025 SHALL, with REG_BUS_R5_EN defined, add 16-bit register R5 written/incremented/cleared via bit 6 and driven on bus at read_en 11.
REQ-026 SHALL, without REG_BUS_R5_EN, contain no R5 storage; bit 6 is ignored and read_en 11 drives zero.

Verification
REQ-027 SHALL verify reset: rst pulse mid-cycle with AC=1234 -> AC=0000, PC=0000, z=0001 before the next edge.
REQ-028 SHALL verify fetch: im_rdata=0013, read_en=13, write_en[3] -> IR=0013, instruction=13; next cycle inc_en[1] with PC=FFFF -> PC=0000.
REQ-029 SHALL verify priority: clr_en[4], write_en[4] and inc_en[4] in one cycle with bus=00AA -> AC=0000, z=0001; write_en[4] and write_en[12] with bus=00AA, alu_result=0055 -> AC=00AA.
REQ-030 SHALL verify register moves: AC=0007, read_en=5, write_en[10] -> R1=0007; read_en=7, write_en[4] -> AC=0007, z=0000.
REQ-031 SHALL verify memory store: AR=0020, AC=BEEF, read_en=5, write_en[11] -> dm_we=1, dm_addr=0020, dm_wdata=BEEF in the same cycle.
REQ-032 SHALL verify the R5 macro both ways: AC=0042, read_en=5, write_en[6], then read_en=11 -> bus=0042 with REG_BUS_R5_EN, bus=0000 without.

Source files
------------

// File: rtl/reg_bus.sv
// reg_bus: register file and shared data bus; define REG_BUS_R5_EN to add register R5
module reg_bus (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  read_en,
    input  logic [15:0] write_en,
    input  logic [15:0] inc_en,
    input  logic [15:0] clr_en,
    input  logic [15:0] alu_result,
    input  logic [15:0] im_rdata,
    input  logic [15:0] dm_rdata,
    output logic [15:0] bus,
    output logic [15:0] im_addr,
    output logic [15:0] dm_addr,
    output logic [15:0] dm_wdata,
    output logic        dm_we,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic [4:0]  instruction,
    output logic [15:0] z
);
    logic [15:0] pc, ar, ir, ac, r, r1, r2, r3, r4, ac_next;
    logic        zf;
`ifdef REG_BUS_R5_EN
    logic [15:0] r5;
    logic        unused_bits;
    assign unused_bits = ^{write_en[15:13], write_en[0], inc_en[15:11], inc_en[0],
                           clr_en[15:11], clr_en[0]};
`else
    logic        unused_bits;
    assign unused_bits = ^{write_en[15:13], write_en[6], write_en[0], inc_en[15:11],
                           inc_en[6], inc_en[0], clr_en[15:11], clr_en[6], clr_en[0]};
`endif

    function automatic logic [15:0] upd(input logic [15:0] q, input logic c, input logic w,
                                        input logic i, input logic [15:0] b);
        return c ? 16'h0000 : w ? b : i ? q + 16'd1 : q;
    endfunction

    // bus source select; unused codes drive zero
    always_comb begin
        case (read_en)
            4'd1:    bus = pc;
            4'd2:    bus = ar;
            4'd4:    bus = ir;
            4'd5:    bus = ac;
            4'd6:    bus = r;
            4'd7:    bus = r1;
            4'd8:    bus = r2;
            4'd9:    bus = r3;
            4'd10:   bus = r4;
`ifdef REG_BUS_R5_EN
            4'd11:   bus = r5;
`endif
            4'd12:   bus = dm_rdata;
            4'd13:   bus = im_rdata;
            4'd14:   bus = ac;
            default: bus = 16'h0000;
        endcase
    end

    // AC next value: clear beats bus load beats ALU load beats increment
    always_comb begin
        ac_next = clr_en[4] ? 16'h0000 : write_en[4] ? bus : write_en[12] ? alu_result :
                  inc_en[4] ? ac + 16'd1 : ac;
    end

    // register updates and zero flag tracking the new AC
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= '0;
            ar <= '0;
            ir <= '0;
            ac <= '0;
            r  <= '0;
            r1 <= '0;
            r2 <= '0;
            r3 <= '0;
            r4 <= '0;
`ifdef REG_BUS_R5_EN
            r5 <= '0;
`endif
            zf <= 1'b1;
        end else begin
            pc <= upd(pc, clr_en[1],  write_en[1],  inc_en[1],  bus);
            ar <= upd(ar, clr_en[2],  write_en[2],  inc_en[2],  bus);
            ir <= upd(ir, clr_en[3],  write_en[3],  inc_en[3],  bus);
            ac <= ac_next;
            r  <= upd(r,  clr_en[5],  write_en[5],  inc_en[5],  bus);
            r4 <= upd(r4, clr_en[7],  write_en[7],  inc_en[7],  bus);
            r3 <= upd(r3, clr_en[8],  write_en[8],  inc_en[8],  bus);
            r2 <= upd(r2, clr_en[9],  write_en[9],  inc_en[9],  bus);
            r1 <= upd(r1, clr_en[10], write_en[10], inc_en[10], bus);
`ifdef REG_BUS_R5_EN
            r5 <= upd(r5, clr_en[6],  write_en[6],  inc_en[6],  bus);
`endif
            zf <= (ac_next == 16'h0000);
        end
    end

    assign im_addr     = pc;
    assign dm_addr     = ar;
    assign dm_wdata    = bus;
    assign dm_we       = write_en[11];
    assign alu_a       = ac;
    assign alu_b       = r;
    assign instruction = ir[4:0];
    assign z           = {15'h0000, zf};
endmodule

// File: tb/tb_reg_bus.sv
// tb_reg_bus: scoreboard bench for reg_bus
module tb_reg_bus;
    logic        clk = 1'b0, rst;
    logic [3:0]  read_en;
    logic [15:0] write_en, inc_en, clr_en, alu_result, im_rdata, dm_rdata;
    logic [15:0] bus, im_addr, dm_addr, dm_wdata, alu_a, alu_b, z;
    logic        dm_we;
    logic [4:0]  instruction;

    localparam int S_PC = 0, S_AR = 1, S_AC = 2, S_R = 3, S_Z = 4, S_INS = 5,
                   S_BUS = 6, S_WE = 7, S_WD = 8;
`ifdef REG_BUS_R5_EN
    localparam logic [15:0] R5_EXP = 16'h0042;
`else
    localparam logic [15:0] R5_EXP = 16'h0000;
`endif

    typedef struct {
        string       tag;
        int          sig;
        logic [15:0] exp;
    } exp_t;
    exp_t sb[$];
    int passed = 0, total = 0;

    reg_bus dut (
        .clk(clk), .rst(rst), .read_en(read_en), .write_en(write_en), .inc_en(inc_en),
        .clr_en(clr_en), .alu_result(alu_result), .im_rdata(im_rdata), .dm_rdata(dm_rdata),
        .bus(bus), .im_addr(im_addr), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_we(dm_we),
        .alu_a(alu_a), .alu_b(alu_b), .instruction(instruction), .z(z)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [15:0] obs(input int s);
        case (s)
            S_PC:    return im_addr;
            S_AR:    return dm_addr;
            S_AC:    return alu_a;
            S_R:     return alu_b;
            S_Z:     return z;
            S_INS:   return {11'h000, instruction};
            S_BUS:   return bus;
            S_WE:    return {15'h0000, dm_we};
            default: return dm_wdata;
        endcase
    endfunction

    task automatic push(input string tag, input int s, input logic [15:0] e);
        sb.push_back('{tag, s, e});
    endtask

    task automatic drain();
        exp_t it;
        while (sb.size() > 0) begin
            it = sb.pop_front();
            check(it.tag, obs(it.sig), it.exp);
        end
    endtask

    task automatic idle();
        read_en = '0; write_en = '0; inc_en = '0; clr_en = '0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        drain();
        idle();
    endtask

    task automatic load(input int b, input logic [15:0] v);
        dm_rdata = v; read_en = 4'd12; write_en = '0; write_en[b] = 1'b1;
        cyc();
    endtask

    initial begin
        idle();
        rst = 1'b1; alu_result = '0; im_rdata = '0; dm_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        push("rst_pc", S_PC, 16'h0000); push("rst_ac", S_AC, 16'h0000); push("rst_z", S_Z, 16'h0001);
        drain();
        rst = 1'b0;
        push("ld_pc", S_PC, 16'h00FF);
        load(1, 16'h00FF);
        push("ld_ac", S_AC, 16'h1234); push("ld_z", S_Z, 16'h0000);
        load(4, 16'h1234);
        #3 rst = 1'b1;
        #1;
        push("arst_ac", S_AC, 16'h0000); push("arst_pc", S_PC, 16'h0000); push("arst_z", S_Z, 16'h0001);
        drain();
        dm_rdata = 16'hFFFF; read_en = 4'd12; write_en[4] = 1'b1; inc_en[1] = 1'b1;
        push("rst_ign_ac", S_AC, 16'h0000); push("rst_ign_pc", S_PC, 16'h0000);
        cyc();
        rst = 1'b0;
        im_rdata = 16'h0013; read_en = 4'd13; write_en[3] = 1'b1;
        push("fetch_ins", S_INS, 16'h0013);
        cyc();
        read_en = 4'd4;
        #1 push("fetch_ir_bus", S_BUS, 16'h0013);
        drain();
        push("pc_ffff", S_PC, 16'hFFFF);
        load(1, 16'hFFFF);
        inc_en[1] = 1'b1;
        push("pc_wrap", S_PC, 16'h0000);
        cyc();
        push("ac_5", S_AC, 16'h0005);
        load(4, 16'h0005);
        dm_rdata = 16'h00AA; read_en = 4'd12; clr_en[4] = 1'b1; write_en[4] = 1'b1; inc_en[4] = 1'b1;
        push("prio_clr_ac", S_AC, 16'h0000); push("prio_clr_z", S_Z, 16'h0001);
        cyc();
        dm_rdata = 16'h00AA; read_en = 4'd12; write_en[4] = 1'b1; write_en[12] = 1'b1; alu_result = 16'h0055;
        push("prio_bus_ac", S_AC, 16'h00AA); push("prio_bus_z", S_Z, 16'h0000);
        cyc();
        write_en[12] = 1'b1; inc_en[4] = 1'b1;
        push("prio_alu_ac", S_AC, 16'h0055);
        cyc();
        inc_en[4] = 1'b1;
        push("inc_ac", S_AC, 16'h0056);
        cyc();
        alu_result = 16'h0000; write_en[12] = 1'b1;
        push("alu_zero_ac", S_AC, 16'h0000); push("alu_zero_z", S_Z, 16'h0001);
        cyc();
        push("ac_7", S_AC, 16'h0007);
        load(4, 16'h0007);
        read_en = 4'd5; write_en[10] = 1'b1;
        cyc();
        read_en = 4'd7;
        #1 push("r1_bus", S_BUS, 16'h0007);
        drain();
        clr_en[4] = 1'b1;
        push("clr_ac", S_AC, 16'h0000);
        cyc();
        read_en = 4'd7; write_en[4] = 1'b1;
        push("mv_ac", S_AC, 16'h0007); push("mv_z", S_Z, 16'h0000);
        cyc();
        dm_rdata = 16'h1111; read_en = 4'd12;
        write_en[5] = 1'b1; write_en[7] = 1'b1; write_en[8] = 1'b1; write_en[9] = 1'b1;
        push("multi_r", S_R, 16'h1111);
        cyc();
        for (int i = 8; i <= 10; i++) begin
            read_en = 4'(i);
            #1 push($sformatf("multi_sel%0d", i), S_BUS, 16'h1111);
            drain();
        end
        read_en = 4'd7;
        #1 push("r1_hold", S_BUS, 16'h0007);
        drain();
        push("ld_ar", S_AR, 16'h0020);
        load(2, 16'h0020);
        load(4, 16'hBEEF);
        read_en = 4'd5; write_en[11] = 1'b1;
        #1 push("st_we", S_WE, 16'h0001); push("st_addr", S_AR, 16'h0020); push("st_wdata", S_WD, 16'hBEEF);
        drain();
        read_en = 4'd0;
        #1 push("st_we_zero", S_WE, 16'h0001); push("st_bus_zero", S_BUS, 16'h0000);
        drain();
        idle();
        #1 push("we_idle", S_WE, 16'h0000);
        drain();
        read_en = 4'd14;
        #1 push("sel14_ac", S_BUS, 16'hBEEF);
        drain();
        read_en = 4'd3;
        #1 push("sel3_zero", S_BUS, 16'h0000);
        drain();
        read_en = 4'd15;
        #1 push("sel15_zero", S_BUS, 16'h0000);
        drain();
        load(4, 16'h0042);
        read_en = 4'd5; write_en[6] = 1'b1;
        cyc();
        read_en = 4'd11;
        #1 push("r5_bus", S_BUS, R5_EXP);
        drain();
        idle();
        #1 push("pc_hold", S_PC, 16'h0000); push("ar_hold", S_AR, 16'h0020);
        drain();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
